// File: rtl/pipelined_alu_ctrl.sv
// Handshaked ALU with registered result and an iterative shift-add multiplier.
// Single-cycle ops complete in one edge; MUL takes WIDTH iterations in BUSY.
module pipelined_alu_ctrl #(
    parameter int WIDTH  = 32,
    parameter bit MUL_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       aluControl,
    input  logic [WIDTH-1:0] SrcA,
    input  logic [WIDTH-1:0] SrcB,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] ALUResult,
    output logic             zero,
    output logic             illegal
);

    localparam int SHW = $clog2(WIDTH);

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_AND  = 4'b0010;
    localparam logic [3:0] OP_OR   = 4'b0011;
    localparam logic [3:0] OP_XOR  = 4'b0100;
    localparam logic [3:0] OP_SLT  = 4'b0101;
    localparam logic [3:0] OP_SRA  = 4'b0110;
    localparam logic [3:0] OP_SRL  = 4'b0111;
    localparam logic [3:0] OP_SLL  = 4'b1000;
    localparam logic [3:0] OP_SLTU = 4'b1001;
    localparam logic [3:0] OP_MUL  = 4'b1010;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t state;
    state_t state_d;

    logic [WIDTH-1:0] comb_res;
    logic             comb_ill;
    logic [SHW-1:0]   shamt;
    logic             is_mul;
    logic             xfer;

    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] acc_sum;
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplier;
    logic [SHW-1:0]   cnt;
    logic             last;

    assign shamt     = SrcB[SHW-1:0];
    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign xfer      = in_valid && in_ready;
    assign is_mul    = MUL_EN && (aluControl == OP_MUL);
    assign last      = (cnt == SHW'(WIDTH - 1));
    assign acc_sum   = acc + (mplier[0] ? mcand : '0);

    always_comb begin
        comb_res = '0;
        comb_ill = 1'b0;
        case (aluControl)
            OP_ADD:  comb_res = SrcA + SrcB;
            OP_SUB:  comb_res = SrcA - SrcB;
            OP_AND:  comb_res = SrcA & SrcB;
            OP_OR:   comb_res = SrcA | SrcB;
            OP_XOR:  comb_res = SrcA ^ SrcB;
            OP_SLT:  comb_res = {{(WIDTH-1){1'b0}},
                                 $signed(SrcA) < $signed(SrcB)};
            OP_SRA:  comb_res = $unsigned($signed(SrcA) >>> shamt);
            OP_SRL:  comb_res = SrcA >> shamt;
            OP_SLL:  comb_res = SrcA << shamt;
            OP_SLTU: comb_res = {{(WIDTH-1){1'b0}}, SrcA < SrcB};
            // MUL result comes from the iterative path, never from here
            OP_MUL:  comb_ill = !MUL_EN;
            default: comb_ill = 1'b1;
        endcase
    end

    always_comb begin
        state_d = state;
        case (state)
            IDLE: if (xfer) state_d = is_mul ? BUSY : DONE;
            BUSY: if (last) state_d = DONE;
            DONE: if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ALUResult <= '0;
            zero      <= 1'b1;
            illegal   <= 1'b0;
            acc       <= '0;
            mcand     <= '0;
            mplier    <= '0;
            cnt       <= '0;
        end else begin
            if (xfer) begin
                if (is_mul) begin
                    mcand  <= SrcA;
                    mplier <= SrcB;
                    acc    <= '0;
                    cnt    <= '0;
                end else begin
                    ALUResult <= comb_res;
                    zero      <= (comb_res == '0);
                    illegal   <= comb_ill;
                end
            end
            if (state == BUSY) begin
                acc    <= acc_sum;
                mcand  <= mcand << 1;
                mplier <= mplier >> 1;
                cnt    <= cnt + SHW'(1);
                // final iteration lands straight in the output register
                if (last) begin
                    ALUResult <= acc_sum;
                    zero      <= (acc_sum == '0);
                    illegal   <= 1'b0;
                end
            end
        end
    end

endmodule
